// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard for the in-order pipeline: tracks in-flight destinations from EXE to WB,
// generates the decode stall, per-source forwarding selects and a saturating stall counter.
// Build option: define SCOREBOARD_FORWARD_EN to generate forwarding selects (load-use is then the only hazard).
module pipe_scoreboard #(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [ADDR_W-1:0]         id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_mem_r,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              wb_en;
    logic              mem_r;
  } entry_t;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // match[i][k]: entry k supplies a value that source i actually reads.
  logic [NUM_SRC-1:0][DEPTH-1:0] match;
  logic                          hazard;

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[i][k] = entry_q[k].valid && entry_q[k].wb_en && id_src_used[i] &&
                      (entry_q[k].dest == id_src[i*ADDR_W +: ADDR_W]);
      end
    end
  end

`ifdef SCOREBOARD_FORWARD_EN
  // Only a load still in EXE cannot be forwarded in time.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (match[i][0] && entry_q[0].mem_r) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Oldest first so the youngest matching entry overwrites and wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[i][k]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
    if (stall) begin
      fwd_sel = '0;
    end
  end
`else
  // Without forwarding, any pending write to a read register blocks decode until it retires.
  assign hazard  = |match;
  assign fwd_sel = '0;
`endif

  assign stall     = hazard & id_valid & ~flush;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    entry_d[0] = '0;
    if (id_valid && !flush && !stall) begin
      entry_d[0].valid = 1'b1;
      entry_d[0].dest  = id_dest;
      entry_d[0].wb_en = id_wb_en;
      entry_d[0].mem_r = id_mem_r;
    end
    for (int k = 1; k < DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the entry array is reset (not left to power-up values) because stale valid bits would stall or forward from garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its pre-edge neighbour, regardless of statement order.
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= entry_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
